ext_lane_stage: RTL and testbench
=================================

# ext_lane_stage

Registered, parametrised extension stage for the CPU datapath. Takes a DATA_W-bit word plus a lane offset and mode, and produces the zero- or sign-extended byte, halfword, full word, or immediate (sign, zero, or upper-shifted) result. Sits between the data-memory read port / immediate field and the writeback/ALU-B mux. Carries a valid/ready handshake with a 2-entry skid buffer so downstream stalls never drop data.

## Interface
- DATA_W, 32: datapath width; 32 or 64 only.
- IMM_W, 16: immediate field width; 1..DATA_W/2.
- LANE_W, $clog2(DATA_W/8): byte-offset width (derived; do not override).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  raw memory word, or immediate in bits [IMM_W-1:0].
- in_off  in  LANE_W  byte offset of the access within in_data.
- in_mode  in  3  0 WORD, 1 BYTE_S, 2 BYTE_U, 3 HALF_S, 4 HALF_U, 5 IMM_S, 6 IMM_U, 7 IMM_HI.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result this cycle.
- out_data  out  DATA_W  extended result.
- out_err  out  1  misaligned access flag, qualified by out_valid.

## Operation
- Function per mode, with lane L = in_off:
  - WORD: in_data unchanged.
  - BYTE_S / BYTE_U: in_data[8L+7:8L], sign- or zero-extended to DATA_W.
  - HALF_S / HALF_U: in_data[8L+15:8L], sign- or zero-extended; in_off[0] must be 0.
  - IMM_S / IMM_U: in_data[IMM_W-1:0], sign- or zero-extended; in_off ignored.
  - IMM_HI: in_data[IMM_W-1:0] << (DATA_W/2), lower half zero; in_off ignored.
- Alignment: WORD requires in_off == 0; HALF requires in_off[0] == 0; BYTE and IMM never misalign.
- Misaligned beat: see Configuration. The beat is still transferred; it is never dropped.
- Storage: output register (O) and skid register (S). Occupancy states:
  - EMPTY: out_valid = 0.
  - ONE: O valid.
  - TWO: O and S valid.
- A beat is accepted when in_valid && in_ready.
- A beat is consumed when out_valid && out_ready.
- Transitions:
  - EMPTY + accept -> ONE; computed beat goes to O.
  - ONE + accept + consume -> ONE; O is replaced.
  - ONE + accept, no consume -> TWO; beat goes to S.
  - ONE + consume, no accept -> EMPTY.
  - TWO + consume -> ONE; S moves to O. No accept is possible in TWO.
- in_ready = !rst && state != TWO. It depends only on registered state, never on out_ready.
- Ordering: strictly FIFO, no reordering.

## Timing
- Reset, synchronous: state = EMPTY; out_valid = 0; out_data = 0; out_err = 0; S cleared.
- in_ready = 0 while rst is high, and 1 the cycle after rst deasserts.
- Reset mid-operation discards O and S contents with no output.
- Latency: an accept at edge N gives out_valid high after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle while out_ready is held high.
- out_data and out_err hold stable while out_valid && !out_ready.
- in_data, in_off and in_mode are sampled only on accept edges; other values are don't-care.
- Extension logic is combinational in front of the registers. O and S hold final results, so no arithmetic happens on the output side.

## Configuration
- EXT_MISALIGN_TRAP_EN defined:
  - A misaligned WORD or HALF beat returns out_data = 0 and out_err = 1.
  - Every aligned beat has out_err = 0.
- EXT_MISALIGN_TRAP_EN undefined:
  - Misaligned offsets are truncated: HALF uses in_off & ~1; WORD uses offset 0.
  - The extended result is returned normally.
  - out_err is tied 0, and no error storage exists in O or S.

## Test plan
- DATA_W=32, BYTE_S, in_data=32'h12F4_5678, in_off=2, out_ready=1 -> out_data=32'hFFFF_FFF4 one cycle later; BYTE_U with the same stimulus -> 32'h0000_00F4.
- HALF_S, in_data=32'h8001_0000, in_off=2 -> 32'hFFFF_8001. IMM_HI, in_data[15:0]=16'h1234 -> 32'h1234_0000. IMM_S with 16'h8000 -> 32'hFFFF_8000.
- HALF_U, in_off=1:
  - with EXT_MISALIGN_TRAP_EN -> out_data=0, out_err=1;
  - without it, in_data=32'hAABB_CCDD -> out_data=32'h0000_CCDD, out_err=0.
- Backpressure: stream beats A, B, C with out_ready=0 -> A held in O, B in S, in_ready=0, C stalled. Raise out_ready -> A, B, C emerge in order, no loss or duplication.
- Assert rst in state TWO -> next cycle out_valid=0, out_data=0, in_ready=0. After rst drops, in_ready=1 and the first new beat emerges after 1 cycle.
- DATA_W=64, BYTE_S, in_data=64'h80<<56, in_off=7 -> 64'hFFFF_FFFF_FFFF_FF80. WORD, in_off=0 -> in_data unchanged.

Source files
------------

// File: rtl/ext_lane_stage.sv
// Registered byte/half/word/immediate extension stage with a 2-entry skid buffer.
// Define EXT_MISALIGN_TRAP_EN to zero misaligned WORD/HALF results and flag out_err.
module ext_lane_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int LANE_W = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LANE_W-1:0] in_off,
    input  logic [2:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    localparam logic [2:0] M_WORD   = 3'd0;
    localparam logic [2:0] M_BYTE_S = 3'd1;
    localparam logic [2:0] M_BYTE_U = 3'd2;
    localparam logic [2:0] M_HALF_S = 3'd3;
    localparam logic [2:0] M_HALF_U = 3'd4;
    localparam logic [2:0] M_IMM_S  = 3'd5;
    localparam logic [2:0] M_IMM_U  = 3'd6;
    localparam logic [2:0] M_IMM_HI = 3'd7;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_o_data;
    logic [DATA_W-1:0] r_s_data;

    logic [LANE_W-1:0] w_off_h;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [IMM_W-1:0]  w_imm;
    logic [DATA_W-1:0] w_imm_z;
    logic [DATA_W-1:0] w_res;
    logic [DATA_W-1:0] w_ext;

    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_acc;
    logic       w_con;
    logic       w_ld_o;
    logic       w_ld_s;
    logic       w_mv;
    logic [1:0] w_state_nxt;

    // Halfword lane is always forced even, so an odd offset never reads past the word.
    assign w_off_h = {in_off[LANE_W-1:1], 1'b0};
    assign w_byte  = in_data[{in_off, 3'b000} +: 8];
    assign w_half  = in_data[{w_off_h, 3'b000} +: 16];
    assign w_imm   = in_data[IMM_W-1:0];
    assign w_imm_z = {{(DATA_W-IMM_W){1'b0}}, w_imm};

    always_comb begin
        w_res = in_data;
        unique case (in_mode)
            M_WORD:   w_res = in_data;
            M_BYTE_S: w_res = {{(DATA_W-8){w_byte[7]}}, w_byte};
            M_BYTE_U: w_res = {{(DATA_W-8){1'b0}}, w_byte};
            M_HALF_S: w_res = {{(DATA_W-16){w_half[15]}}, w_half};
            M_HALF_U: w_res = {{(DATA_W-16){1'b0}}, w_half};
            M_IMM_S:  w_res = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
            M_IMM_U:  w_res = w_imm_z;
            M_IMM_HI: w_res = w_imm_z << (DATA_W/2);
            default:  w_res = in_data;
        endcase
    end

`ifdef EXT_MISALIGN_TRAP_EN
    logic w_mis;
    logic r_o_err;
    logic r_s_err;

    always_comb begin
        w_mis = 1'b0;
        unique case (in_mode)
            M_WORD:   w_mis = (in_off != '0);
            M_HALF_S: w_mis = in_off[0];
            M_HALF_U: w_mis = in_off[0];
            default:  w_mis = 1'b0;
        endcase
    end

    assign w_ext = w_mis ? '0 : w_res;
`else
    assign w_ext = w_res;
`endif

    // in_ready looks only at registered occupancy, never at out_ready.
    assign w_in_ready  = !rst && (r_state != ST_TWO);
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_acc       = in_valid && w_in_ready;
    assign w_con       = w_out_valid && out_ready;

    always_comb begin
        w_ld_o      = 1'b0;
        w_ld_s      = 1'b0;
        w_mv        = 1'b0;
        w_state_nxt = r_state;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_ld_o      = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_acc && w_con) begin
                    w_ld_o = 1'b1;
                end else if (w_acc) begin
                    w_ld_s      = 1'b1;
                    w_state_nxt = ST_TWO;
                end else if (w_con) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_con) begin
                    w_mv        = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_o_data <= '0;
            r_s_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ld_o) begin
                r_o_data <= w_ext;
            end else if (w_mv) begin
                r_o_data <= r_s_data;
            end
            if (w_ld_s) begin
                r_s_data <= w_ext;
            end
        end
    end

`ifdef EXT_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_err <= 1'b0;
            r_s_err <= 1'b0;
        end else begin
            if (w_ld_o) begin
                r_o_err <= w_mis;
            end else if (w_mv) begin
                r_o_err <= r_s_err;
            end
            if (w_ld_s) begin
                r_s_err <= w_mis;
            end
        end
    end

    assign out_err = r_o_err;
`else
    assign out_err = 1'b0;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_o_data;

endmodule

// File: tb/tb_ext_lane_stage.sv
// Directed bench for ext_lane_stage: vector table plus backpressure and reset sequences.
// Expected values follow EXT_MISALIGN_TRAP_EN when it is defined.
module tb_ext_lane_stage;

`ifdef EXT_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_off;
    logic [2:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    logic        v64_in_valid;
    logic        v64_in_ready;
    logic [63:0] v64_in_data;
    logic [2:0]  v64_in_off;
    logic [2:0]  v64_in_mode;
    logic        v64_out_valid;
    logic        v64_out_ready;
    logic [63:0] v64_out_data;
    logic        v64_out_err;

    int checks;
    int failures;

    typedef struct {
        logic [2:0]  mode;
        logic [1:0]  off;
        logic [31:0] data;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vecs[14];

    ext_lane_stage #(.DATA_W(32), .IMM_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_off(in_off), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    ext_lane_stage #(.DATA_W(64), .IMM_W(16)) u_dut64 (
        .clk(clk), .rst(rst),
        .in_valid(v64_in_valid), .in_ready(v64_in_ready),
        .in_data(v64_in_data), .in_off(v64_in_off), .in_mode(v64_in_mode),
        .out_valid(v64_out_valid), .out_ready(v64_out_ready),
        .out_data(v64_out_data), .out_err(v64_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] m, input logic [1:0] o, input logic [31:0] d);
        in_valid = 1'b1;
        in_mode  = m;
        in_off   = o;
        in_data  = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{3'd1, 2'd2, 32'h12F4_5678, 32'hFFFF_FFF4, 1'b0};
        vecs[1]  = '{3'd2, 2'd2, 32'h12F4_5678, 32'h0000_00F4, 1'b0};
        vecs[2]  = '{3'd3, 2'd2, 32'h8001_0000, 32'hFFFF_8001, 1'b0};
        vecs[3]  = '{3'd7, 2'd1, 32'hFFFF_1234, 32'h1234_0000, 1'b0};
        vecs[4]  = '{3'd5, 2'd3, 32'h0000_8000, 32'hFFFF_8000, 1'b0};
        vecs[5]  = '{3'd6, 2'd0, 32'hFFFF_8000, 32'h0000_8000, 1'b0};
        vecs[6]  = '{3'd0, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{3'd4, 2'd1, 32'hAABB_CCDD,
                     TRAP ? 32'h0 : 32'h0000_CCDD, TRAP};
        vecs[8]  = '{3'd0, 2'd3, 32'h1234_5678,
                     TRAP ? 32'h0 : 32'h1234_5678, TRAP};
        vecs[9]  = '{3'd1, 2'd0, 32'h0000_0080, 32'hFFFF_FF80, 1'b0};
        vecs[10] = '{3'd2, 2'd3, 32'h7F00_0000, 32'h0000_007F, 1'b0};
        vecs[11] = '{3'd4, 2'd2, 32'hAABB_CCDD, 32'h0000_AABB, 1'b0};
        vecs[12] = '{3'd3, 2'd3, 32'hAABB_CCDD,
                     TRAP ? 32'h0 : 32'hFFFF_AABB, TRAP};
        vecs[13] = '{3'd5, 2'd0, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_mode = 3'd0;
        in_off = 2'd0;
        in_data = 32'h0;
        out_ready = 1'b0;
        v64_in_valid = 1'b0;
        v64_in_data = 64'h0;
        v64_in_off = 3'd0;
        v64_in_mode = 3'd0;
        v64_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].mode, vecs[i].off, vecs[i].data);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].exp_d));
            chk($sformatf("vec%0d_err", i), 64'(out_err), 64'(vecs[i].exp_e));
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Backpressure: A in O, B in S, C stalled.
        @(negedge clk);
        out_ready = 1'b0;
        drive(3'd0, 2'd0, 32'h0A0A_0A0A);
        @(negedge clk);
        drive(3'd0, 2'd0, 32'h0B0B_0B0B);
        @(posedge clk);
        #1;
        chk("bp_two_in_ready", 64'(in_ready), 64'd0);
        chk("bp_two_data_a", 64'(out_data), 64'h0A0A_0A0A);
        @(negedge clk);
        drive(3'd0, 2'd0, 32'h0C0C_0C0C);
        @(posedge clk);
        #1;
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_data_a", 64'(out_data), 64'h0A0A_0A0A);
        chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_out_b", 64'(out_data), 64'h0B0B_0B0B);
        chk("bp_ready_again", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("bp_out_c", 64'(out_data), 64'h0C0C_0C0C);
        chk("bp_out_c_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_no_dup", 64'(out_valid), 64'd0);

        // Reset while holding two beats.
        @(negedge clk);
        out_ready = 1'b0;
        drive(3'd0, 2'd0, 32'h0D0D_0D0D);
        @(negedge clk);
        drive(3'd0, 2'd0, 32'h0E0E_0E0E);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rst2_pre_two", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_out_valid", 64'(out_valid), 64'd0);
        chk("rst2_out_data", 64'(out_data), 64'd0);
        chk("rst2_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst2_ready_after", 64'(in_ready), 64'd1);
        chk("rst2_still_empty", 64'(out_valid), 64'd0);
        drive(3'd2, 2'd1, 32'h0000_5A00);
        @(posedge clk);
        #1;
        chk("rst2_first_valid", 64'(out_valid), 64'd1);
        chk("rst2_first_data", 64'(out_data), 64'h0000_005A);
        @(negedge clk);
        in_valid = 1'b0;

        // 64-bit instance.
        v64_in_valid = 1'b1;
        v64_in_mode  = 3'd1;
        v64_in_off   = 3'd7;
        v64_in_data  = 64'h80 << 56;
        @(posedge clk);
        #1;
        chk("w64_byte_s_valid", 64'(v64_out_valid), 64'd1);
        chk("w64_byte_s", v64_out_data, 64'hFFFF_FFFF_FFFF_FF80);
        @(negedge clk);
        v64_in_mode = 3'd0;
        v64_in_off  = 3'd0;
        v64_in_data = 64'h0123_4567_89AB_CDEF;
        @(posedge clk);
        #1;
        chk("w64_word", v64_out_data, 64'h0123_4567_89AB_CDEF);
        chk("w64_word_err", 64'(v64_out_err), 64'd0);
        @(negedge clk);
        v64_in_mode = 3'd7;
        v64_in_off  = 3'd5;
        v64_in_data = 64'hFFFF_FFFF_FFFF_1234;
        @(posedge clk);
        #1;
        chk("w64_imm_hi", v64_out_data, 64'h0000_1234_0000_0000);
        @(negedge clk);
        v64_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("w64_empty", 64'(v64_out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
